// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-way round-robin arbiter with hold limit, index and one-hot grant outputs
// Ports: clk_i clock; rst_ni async active-low reset; req_i[3:0] level requests;
//   done_i holder finished; gnt_o[3:0] one-hot grant; gnt_idx_o[1:0] holder index
//   (held while idle); gnt_valid_o grant active; timeout_o one-cycle forced-release pulse.
module rr_arbiter4 #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] req_i,
  input  logic       done_i,
  output logic [3:0] gnt_o,
  output logic [1:0] gnt_idx_o,
  output logic       gnt_valid_o,
  output logic       timeout_o
);
  localparam logic [7:0] LIMIT = 8'(MAX_HOLD - 1);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;
  logic [0:0] state_q, state_d;
  logic [1:0] ptr_q, ptr_d, idx_q, idx_d, start, win;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] gnt_q, gnt_d;
  logic       valid_q, valid_d, to_q, to_d, found, at_limit, rel;
  // On release the scan starts just past the holder, so the holder is checked last
  // and a sole remaining requester is re-granted without a bubble.
  always_comb begin
    start = state_q == GRANT ? idx_q + 2'd1 : ptr_q;
    found = 1'b0;
    win   = start;
    for (int i = 3; i >= 0; i--) begin
      if (req_i[start + 2'(i)]) begin
        found = 1'b1;
        win   = start + 2'(i);
      end
    end
  end
  assign at_limit = cnt_q == LIMIT;
  assign rel      = state_q == GRANT && (done_i || !req_i[idx_q] || at_limit);
  always_comb begin
    state_d = state_q;
    ptr_d   = rel ? idx_q + 2'd1 : ptr_q;
    cnt_d   = cnt_q + 8'd1;
    idx_d   = idx_q;
    gnt_d   = gnt_q;
    valid_d = valid_q;
    to_d    = rel && at_limit && !done_i && req_i[idx_q];
    if (state_q == IDLE || rel) begin
      state_d = found ? GRANT : IDLE;
      idx_d   = found ? win : idx_q;
      gnt_d   = found ? 4'b0001 << win : 4'b0000;
      valid_d = found;
      cnt_d   = 8'd0;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      cnt_q   <= 8'd0;
      idx_q   <= 2'd0;
      gnt_q   <= 4'b0000;
      valid_q <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      to_q    <= to_d;
    end
  end
  assign gnt_o       = gnt_q;
  assign gnt_idx_o   = idx_q;
  assign gnt_valid_o = valid_q;
  assign timeout_o   = to_q;
endmodule

// File: tb/tb_rr_arbiter4.sv
// tb_rr_arbiter4: directed self-checking bench for rr_arbiter4 with MAX_HOLD=8
module tb_rr_arbiter4;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b1111;
  logic       done = 1'b0;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid, timeout;
  int         errs = 0, checks = 0;
  rr_arbiter4 #(.MAX_HOLD(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .done_i(done),
    .gnt_o(gnt), .gnt_idx_o(gnt_idx), .gnt_valid_o(gnt_valid), .timeout_o(timeout)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [3:0] g, input logic [1:0] ix,
                     input logic v, input logic t);
    checks += 4;
    assert (gnt === g) else begin errs++; $error("FAIL %s gnt got %b want %b", tag, gnt, g); end
    assert (gnt_idx === ix) else begin errs++; $error("FAIL %s idx got %0d want %0d", tag, gnt_idx, ix); end
    assert (gnt_valid === v) else begin errs++; $error("FAIL %s valid got %b want %b", tag, gnt_valid, v); end
    assert (timeout === t) else begin errs++; $error("FAIL %s timeout got %b want %b", tag, timeout, t); end
  endtask
  initial begin
    tick;
    tick;
    chk("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    req = 4'b0010;
    tick;
    chk("single_grant", 4'b0010, 2'd1, 1'b1, 1'b0);
    req = 4'b0000;
    tick;
    chk("single_drop", 4'b0000, 2'd1, 1'b0, 1'b0);
    req = 4'b1111;
    tick;
    chk("grant_from_ptr2", 4'b0100, 2'd2, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick;
    rst_n = 1'b1;
    tick;
    chk("post_reset_ptr0", 4'b0001, 2'd0, 1'b1, 1'b0);
    done = 1'b1;
    tick;
    chk("rr_1", 4'b0010, 2'd1, 1'b1, 1'b0);
    tick;
    chk("rr_2", 4'b0100, 2'd2, 1'b1, 1'b0);
    tick;
    chk("rr_3", 4'b1000, 2'd3, 1'b1, 1'b0);
    tick;
    chk("rr_0", 4'b0001, 2'd0, 1'b1, 1'b0);
    req = 4'b0101;
    tick;
    chk("rot_to_2", 4'b0100, 2'd2, 1'b1, 1'b0);
    tick;
    chk("rot_2_to_0", 4'b0001, 2'd0, 1'b1, 1'b0);
    tick;
    chk("rot_0_to_2", 4'b0100, 2'd2, 1'b1, 1'b0);
    done = 1'b0;
    req = 4'b0000;
    tick;
    chk("idle_hold_idx", 4'b0000, 2'd2, 1'b0, 1'b0);
    req = 4'b0011;
    tick;
    chk("to_grant0", 4'b0001, 2'd0, 1'b1, 1'b0);
    for (int i = 1; i < 8; i++) begin
      tick;
      chk($sformatf("hold0_c%0d", i), 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    tick;
    chk("timeout_switch", 4'b0010, 2'd1, 1'b1, 1'b1);
    tick;
    chk("timeout_pulse_end", 4'b0010, 2'd1, 1'b1, 1'b0);
    for (int i = 2; i < 8; i++) begin
      tick;
      chk($sformatf("hold1_c%0d", i), 4'b0010, 2'd1, 1'b1, 1'b0);
    end
    done = 1'b1;
    tick;
    chk("done_at_limit", 4'b0001, 2'd0, 1'b1, 1'b0);
    done = 1'b0;
    req = 4'b1000;
    tick;
    chk("sole_grant3", 4'b1000, 2'd3, 1'b1, 1'b0);
    for (int i = 1; i < 8; i++) begin
      tick;
      chk($sformatf("hold3_c%0d", i), 4'b1000, 2'd3, 1'b1, 1'b0);
    end
    tick;
    chk("sole_regrant_timeout", 4'b1000, 2'd3, 1'b1, 1'b1);
    tick;
    chk("sole_regrant_hold", 4'b1000, 2'd3, 1'b1, 1'b0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/rr_arbiter4.md
# rr_arbiter4

Four-way round-robin arbiter that shares one resource selected through the 2-to-4 decoder among four requesters. It picks one winner per grant period, exposes the winner as a 2-bit index (decoder select input) and as the decoded one-hot grant, and holds the grant until the holder signals done, withdraws its request, or exceeds a hold limit. Priority rotates so the last holder becomes lowest priority.

## Interface
- MAX_HOLD, default 8: maximum cycles a single grant may stay valid; legal range 2..256.

- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- req  input  4  request vector, bit i = requester i; level-sensitive, held until served.
- done  input  1  current holder finished; sampled only while gnt_valid=1.
- gnt  output  4  one-hot grant; equals decode(gnt_idx) when gnt_valid=1, else 4'b0000.
- gnt_idx  output  2  index of current holder (decoder select); holds last value when idle.
- gnt_valid  output  1  a grant is active.
- timeout  output  1  one-cycle pulse: previous grant was forcibly revoked at MAX_HOLD.

## Operation
- Internal state: ptr[1:0] (highest-priority requester), hold counter cnt[7:0], state IDLE/GRANT.
- Reset (rst_n=0, takes effect immediately): state=IDLE, gnt=0000, gnt_idx=00, gnt_valid=0, timeout=0, ptr=00, cnt=0.
- Winner function: first set bit of req scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- IDLE: if req != 0, at next edge go GRANT, gnt_idx=winner(ptr), gnt=decode(winner), gnt_valid=1, cnt=0. If req == 0, stay IDLE, outputs zero (gnt_idx unchanged).
- GRANT: each cycle evaluate release = done | ~req[gnt_idx] | (cnt == MAX_HOLD-1).
  - No release: cnt increments, grant unchanged.
  - Release: ptr <= gnt_idx+1 (mod 4). Re-arbitrate the same cycle with the scan starting at gnt_idx+1 over the current req, with req[gnt_idx] excluded only when it is low. If a winner exists, load the new grant at the next edge with cnt=0 and stay in GRANT (no idle bubble). Otherwise go IDLE with gnt=0000 and gnt_valid=0.
- timeout <= release & (cnt == MAX_HOLD-1) & ~done & req[gnt_idx]; it is 0 in every other cycle. A done or dropped request in the limit cycle is a normal release, not a timeout.
- A sole requester that is still requesting after release is re-granted immediately; it gets a fresh counter.
- gnt is always one-hot or zero, and is never multi-hot.
- All outputs are registered.

## Timing
- Request-to-grant latency from IDLE is 1 cycle: req sampled at edge N, gnt_valid=1 after edge N.
- Holder sees at most MAX_HOLD consecutive cycles with gnt_valid=1 per grant.
- Release-to-next-grant latency is 0 bubbles: the new gnt appears on the edge following the release cycle.
- timeout is high for exactly the one cycle after the forced-release edge, coincident with the next grant (or idle).
- done and req changes are sampled at the rising edge only; glitches between edges are ignored.
- Asserting rst_n mid-grant clears gnt and gnt_valid asynchronously. The first grant after release of rst_n uses ptr=0.
- All four requesters can be served within 4·MAX_HOLD cycles, so no requester starves.

## Test plan
- Reset: hold rst_n=0 with req=1111 -> gnt=0000, gnt_valid=0, gnt_idx=00, timeout=0. Pulse rst_n low mid-grant -> gnt=0000 before the next edge.
- Single requester: req=0010 at edge N -> after edge N gnt=0010, gnt_idx=01, gnt_valid=1. Drop req -> gnt=0000 and gnt_valid=0 after the next edge.
- Round robin: req=1111, done pulsed one cycle each grant -> grant order idx 0,1,2,3,0, with no idle cycle between grants.
- Priority rotation: holder idx 2 releases with req=0101 -> next gnt_idx=00. Ptr then 1; with req=0101 pending, the grant after that is idx 2.
- Timeout, MAX_HOLD=8: req=0001 and req=0010 held, done=0 -> idx 0 held exactly 8 cycles, timeout=1 for one cycle as gnt switches to 0010.
- done in the limit cycle (cnt=7, done=1) -> release with timeout=0. Sole requester req=1000 timing out -> re-granted idx 3 immediately with timeout=1.
